shift_add_control: RTL and testbench

- Control FSM for the N-bit shift-add multiplier. It sequences operand load, conditional add, and shift steps.
- Drives the iteration counter: parallel load of N, then decrement once per shift. Consumes the counter's zero flag to terminate.
- Provides a start/busy/done handshake to the host and a sticky protocol-error flag that cross-checks the counter against an internal shift tally.

---
 rtl/shift_add_control_if.sv | 33 +++
 rtl/shift_add_control.sv | 88 ++++++++
 tb/tb_shift_add_control.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_add_control_if.sv
// rtl/shift_add_control_if.sv - host handshake and datapath strobe bundle for the shift-add control FSM
interface shift_add_control_if #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
);
    logic          start;
    logic          abort;
    logic          q0;
    logic          cnt_end;
    logic          ld_operands;
    logic          acc_clr;
    logic          acc_add;
    logic          shift;
    logic          cnt_load;
    logic          cnt_en;
    logic          cnt_up_down;
    logic [CW-1:0] cnt_data_in;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, abort, q0, cnt_end,
        input  ld_operands, acc_clr, acc_add, shift, cnt_load, cnt_en,
               cnt_up_down, cnt_data_in, busy, done, err
    );

    modport slave (
        input  start, abort, q0, cnt_end,
        output ld_operands, acc_clr, acc_add, shift, cnt_load, cnt_en,
               cnt_up_down, cnt_data_in, busy, done, err
    );
endinterface

// File: rtl/shift_add_control.sv
// rtl/shift_add_control.sv - Moore control FSM sequencing load/add/shift steps of an N-bit shift-add multiplier
module shift_add_control #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic                clk,
    input  logic                rst,
    shift_add_control_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_TEST  = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CW-1:0] N_CW = CW'(N);

    logic [2:0]    state;
    logic [CW-1:0] tally;
    logic          err_q;
    logic          tally_full;

    assign tally_full = (tally == N_CW);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            tally <= '0;
            err_q <= 1'b0;
        end else if (bus.abort && state != S_IDLE && state != S_DONE) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_LOAD;
                        err_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    tally <= '0;
                    state <= S_TEST;
                end
                S_TEST: begin
                    // The counter and the shift tally must agree on when the last bit went by.
                    if (bus.cnt_end && tally_full) begin
                        state <= S_DONE;
                    end else if (bus.cnt_end ^ tally_full) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else if (bus.q0) begin
                        state <= S_ADD;
                    end else begin
                        state <= S_SHIFT;
                    end
                end
                S_ADD: begin
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!tally_full) begin
                        tally <= tally + 1'b1;
                    end
                    state <= S_TEST;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ld_operands = (state == S_LOAD);
    assign bus.acc_clr     = (state == S_LOAD);
    assign bus.cnt_load    = (state == S_LOAD);
    assign bus.acc_add     = (state == S_ADD);
    assign bus.shift       = (state == S_SHIFT);
    assign bus.cnt_en      = (state == S_SHIFT);
    assign bus.cnt_up_down = 1'b0;
    assign bus.cnt_data_in = N_CW;
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = (state == S_DONE);
    assign bus.err         = err_q;
endmodule

// File: tb/tb_shift_add_control.sv
// tb/tb_shift_add_control.sv - scoreboard bench for shift_add_control with a behavioural counter/multiplier environment
module tb_shift_add_control;
    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shift_add_control_if #(.N(N)) bus ();

    shift_add_control #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit aborted;
        int len;
        int adds;
        int shifts;
        bit err;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int ones(input logic [N-1:0] v, input int nb);
        int c = 0;
        for (int i = 0; i < nb; i++) c += int'(v[i]);
        return c;
    endfunction

    // Environment: multiplier shift register and down counter reacting to the strobes
    logic [N-1:0] mreg;
    logic [N-1:0] operand;
    int           cnt;
    int           env_shifts;
    int           cnt_mode;

    always @(posedge clk) begin
        if (rst) begin
            cnt        <= 0;
            mreg       <= '0;
            env_shifts <= 0;
        end else begin
            if (bus.cnt_load) begin
                cnt        <= int'(bus.cnt_data_in);
                env_shifts <= 0;
            end else if (bus.cnt_en) begin
                cnt        <= bus.cnt_up_down ? cnt + 1 : cnt - 1;
                env_shifts <= env_shifts + 1;
            end
            if (bus.ld_operands) mreg <= operand;
            else if (bus.shift)  mreg <= mreg >> 1;
        end
    end

    assign bus.q0      = mreg[0];
    assign bus.cnt_end = (cnt_mode == 0) ? (cnt == 0) :
                         (cnt_mode == 1) ? (env_shifts >= 5) : 1'b0;

    // Monitor: tallies strobes per run and compares at done or at an early exit
    bit in_run   = 0;
    bit idle_err = 0;
    int m_len, m_adds, m_shifts, m_cnt_en;

    always @(negedge clk) begin
        exp_t e;
        if (bus.busy) begin
            if (!in_run) begin
                in_run   = 1;
                m_len    = 0;
                m_adds   = 0;
                m_shifts = 0;
                m_cnt_en = 0;
                check("load_strobes", int'({bus.ld_operands, bus.acc_clr, bus.cnt_load}), 7);
                check("cnt_data_in", int'(bus.cnt_data_in), N);
            end else begin
                check("cnt_load_once", int'(bus.cnt_load), 0);
            end
            check("cnt_up_down", int'(bus.cnt_up_down), 0);
            m_len++;
            m_adds   += int'(bus.acc_add);
            m_shifts += int'(bus.shift);
            m_cnt_en += int'(bus.cnt_en);
            if (bus.done) begin
                in_run = 0;
                if (sbq.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("done_unexpected", 0, int'(e.aborted));
                    check("run_len", m_len, e.len);
                    check("acc_add_count", m_adds, e.adds);
                    check("shift_count", m_shifts, e.shifts);
                    check("cnt_en_count", m_cnt_en, e.shifts);
                    check("err_at_done", int'(bus.err), int'(e.err));
                    idle_err = e.err;
                end
            end
        end else begin
            if (in_run) begin
                in_run = 0;
                if (sbq.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("missing_done", 1, int'(e.aborted));
                    check("abort_len", m_len, e.len);
                    check("abort_adds", m_adds, e.adds);
                    check("abort_shifts", m_shifts, e.shifts);
                    idle_err = 0;
                end
            end
            check("idle_strobes", int'({bus.ld_operands, bus.acc_clr, bus.acc_add, bus.shift,
                                        bus.cnt_load, bus.cnt_en, bus.done}), 0);
            check("idle_err", int'(bus.err), int'(idle_err));
        end
    end

    // mode 0: correct counter, 1: counter ends after 5 shifts, 2: counter never ends
    task automatic run(input logic [N-1:0] op, input int mode, input int abort_at);
        exp_t e;
        int   nsh;
        int   shift_seen = 0;
        bit   ended      = 0;
        @(posedge clk); #1;
        operand  = op;
        cnt_mode = mode;
        if (abort_at > 0) begin
            e.aborted = 1;
            e.shifts  = abort_at;
            e.adds    = ones(op, abort_at);
            e.len     = 1 + 2 * abort_at + e.adds;
            e.err     = 0;
        end else begin
            nsh       = (mode == 1) ? 5 : N;
            e.aborted = 0;
            e.shifts  = nsh;
            e.adds    = ones(op, nsh);
            // LOAD, nsh x (TEST, optional ADD, SHIFT), final TEST, DONE
            e.len     = 1 + 2 * nsh + e.adds + 2;
            e.err     = (mode != 0);
        end
        sbq.push_back(e);
        bus.start = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (!bus.busy) begin
                ended = 1;
                break;
            end
            bus.abort = 1'b0;
            if (abort_at > 0 && bus.shift) begin
                shift_seen++;
                if (shift_seen == abort_at) bus.abort = 1'b1;
            end
            if (abort_at == 0 && bus.done) bus.abort = 1'b1;
            bus.start = bus.done ? 1'b0 : ($urandom_range(3) == 0);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("run_terminated", int'(ended), 1);
    endtask

    task automatic rst_in_add_run(input logic [N-1:0] op);
        exp_t e;
        bit   hit   = 0;
        bit   ended = 0;
        @(posedge clk); #1;
        operand   = op | {{(N-1){1'b0}}, 1'b1};
        cnt_mode  = 0;
        e.aborted = 1; e.len = 3; e.adds = 1; e.shifts = 0; e.err = 0;
        sbq.push_back(e);
        bus.start = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.acc_add) begin
                hit = 1;
                break;
            end
        end
        check("reached_add", int'(hit), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_outputs", int'({bus.busy, bus.done, bus.err, bus.ld_operands, bus.acc_clr,
                                   bus.acc_add, bus.shift, bus.cnt_load, bus.cnt_en}), 0);
        rst = 1'b0;
        e.aborted = 0;
        e.shifts  = N;
        e.adds    = ones(operand, N);
        e.len     = 1 + 2 * N + e.adds + 2;
        e.err     = 0;
        sbq.push_back(e);
        @(posedge clk); #1;
        check("restart_load", int'(bus.ld_operands), 1);
        bus.start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk); #1;
            if (!bus.busy) begin
                ended = 1;
                break;
            end
        end
        check("restart_terminated", int'(ended), 1);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        operand   = '0;
        cnt_mode  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_err", int'(bus.err), 0);
        rst = 1'b0;

        run(8'h00, 0, 0);
        run(8'h8D, 0, 0);
        run(8'hFF, 0, 0);
        run(8'($urandom), 1, 0);
        run(8'($urandom), 0, 0);
        run(8'($urandom), 2, 0);
        run(8'($urandom), 0, 0);
        run(8'($urandom), 0, 3);
        rst_in_add_run(8'($urandom));

        for (int i = 0; i < 24; i++) begin
            int m;
            int ab;
            m  = ($urandom_range(4) == 0) ? int'($urandom_range(2, 1)) : 0;
            ab = (m == 0 && $urandom_range(3) == 0) ? int'($urandom_range(N, 1)) : 0;
            run(8'($urandom), m, ab);
        end

        repeat (4) @(posedge clk);
        #1;
        check("sb_leftover", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
